wdg_supervisor: RTL and testbench
=================================

# wdg_supervisor

Recovery sequencer for the `watchdog` timeout block. It generates the sampling tick, clears and arms the timer, and synchronizes the heartbeat from the monitored system. On a timeout it drives a timed recovery reset into that system, waits a boot hold-off, then re-arms. It counts consecutive faults and locks out after a configured limit.

## Interface
- TICK_DIV, 50: clk cycles per sampling tick; legal range ≥2.
- RST_CYCLES, 16: cycles `sys_rst` is held during a recovery; ≥1.
- HOLDOFF_TICKS, 8: ticks waited after recovery before re-arming; ≥1.
- MAX_FAULTS, 3: fault count that enters LOCKOUT; legal range 1..15.
- GOOD_TICKS, 64: consecutive error-free RUN ticks that clear `fault_cnt`; ≥1.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs go to reset values immediately.
- enable  in  1  level; 1 = supervise, 0 = return to IDLE.
- wdg_in  in  1  raw heartbeat from the monitored system; asynchronous.
- wdt_error  in  1  timeout flag from the watchdog timer.
- clear_lock  in  1  single-cycle pulse that exits LOCKOUT.
- wdg_sync  out  1  `wdg_in` after a 2-flop synchronizer; feeds the timer's `wdg`.
- pulso  out  1  one-cycle sampling tick; feeds the timer's `pulso`.
- wdt_reset_n  out  1  active-low clear to the timer (timer reset polarity).
- sys_rst  out  1  active-high recovery reset to the monitored system.
- fault_cnt  out  4  consecutive fault count.
- lockout  out  1  1 while in LOCKOUT.
- state  out  3  IDLE=0, ARM=1, RUN=2, RECOVER=3, HOLDOFF=4, LOCKOUT=5.

## Operation
- Reset values:
  - state = IDLE
  - pulso = 0, wdt_reset_n = 0, sys_rst = 0, fault_cnt = 0, lockout = 0
  - wdg_sync = 0, synchronizer flops = 0
  - all internal counters = 0
- Prescaler:
  - Runs only in RUN and HOLDOFF; it is 0 in every other state.
  - Counts 0..TICK_DIV-1 and wraps.
  - The internal tick fires on the count = TICK_DIV-1 cycle.
  - `pulso` = tick, gated to RUN only.
- IDLE:
  - wdt_reset_n = 0, sys_rst = 0.
  - enable = 1 → ARM.
- ARM:
  - Lasts exactly 1 cycle; wdt_reset_n = 0.
  - Clears the prescaler and the good-tick counter.
  - → RUN.
- RUN:
  - wdt_reset_n = 1.
  - Each tick without wdt_error increments the good-tick counter.
  - When the good-tick counter reaches GOOD_TICKS: fault_cnt := 0 and the counter restarts at 0.
  - wdt_error = 1: fault_cnt := fault_cnt+1, saturating at 15.
    - If the new value equals MAX_FAULTS → LOCKOUT.
    - Otherwise → RECOVER.
- RECOVER:
  - sys_rst = 1, wdt_reset_n = 0 for exactly RST_CYCLES cycles.
  - → HOLDOFF.
- HOLDOFF:
  - sys_rst = 0, wdt_reset_n = 0.
  - Counts HOLDOFF_TICKS internal ticks, then → ARM.
- LOCKOUT:
  - sys_rst = 1, lockout = 1, wdt_reset_n = 0, held indefinitely.
  - clear_lock = 1 → fault_cnt := 0, → IDLE.
- enable = 0 in any state except LOCKOUT → IDLE next cycle.
  - sys_rst drops at that edge.
  - fault_cnt is kept.
- Priority within one cycle:
  - enable = 0 wins over wdt_error; no fault is counted.
  - wdt_error wins over a good-tick clear landing on the same cycle.
  - clear_lock outside LOCKOUT is ignored.
  - enable is ignored in LOCKOUT; only clear_lock or reset exits.
- Reset asserted mid-RECOVER or mid-LOCKOUT: sys_rst and lockout drop asynchronously and the FSM returns to IDLE.

## Timing
- All outputs are registered.
- wdg_sync lags wdg_in by 2 edges.
- wdt_error high at edge N:
  - state = RECOVER (or LOCKOUT), sys_rst = 1, wdt_reset_n = 0 visible after edge N.
  - fault_cnt updates on the same edge.
- Recovery timing:
  - sys_rst is high for RST_CYCLES clocks.
  - HOLDOFF lasts HOLDOFF_TICKS·TICK_DIV clocks.
  - ARM lasts 1 clock.
  - With defaults, wdt_error → next RUN takes 16+400+1 = 417 clocks.
- First pulso after entering RUN comes TICK_DIV clocks after the ARM cycle (cycle TICK_DIV of RUN), then every TICK_DIV clocks.
- enable rise in IDLE at edge N: ARM at N+1, RUN at N+2.

## Test plan
- Reset, then enable = 1 with defaults:
  - state goes 0→1→2.
  - wdt_reset_n rises entering RUN.
  - pulso occurs every 50 clocks, one cycle wide.
  - sys_rst stays 0.
- In RUN, pulse wdt_error once:
  - Next edge gives sys_rst = 1 for exactly 16 clocks and fault_cnt = 1.
  - HOLDOFF lasts 400 clocks with no pulso.
  - Then ARM, then RUN.
- Three wdt_error events with fewer than 64 good ticks between them:
  - fault_cnt goes 1, 2, 3.
  - Third event gives LOCKOUT with lockout = 1 and sys_rst held.
  - Toggling enable does nothing.
  - clear_lock gives IDLE and fault_cnt = 0.
- One fault, then 64 error-free ticks in RUN: fault_cnt returns to 0 on the 64th tick.
- wdt_error and enable = 0 in the same cycle in RUN: IDLE next cycle, fault_cnt unchanged, sys_rst never asserts.
- Assert reset 5 clocks into RECOVER: sys_rst, lockout and pulso fall immediately, state = 0, fault_cnt = 0.

Source files
------------

// File: rtl/wdg_supervisor_if.sv
// Signal bundle between the watchdog recovery supervisor and its environment.
// The supervisor takes the slave side; the environment (or bench) takes the master side.
interface wdg_supervisor_if;
    logic       enable;
    logic       wdg_in;
    logic       wdt_error;
    logic       clear_lock;
    logic       wdg_sync;
    logic       pulso;
    logic       wdt_reset_n;
    logic       sys_rst;
    logic [3:0] fault_cnt;
    logic       lockout;
    logic [2:0] state;

    modport slave (
        input  enable, wdg_in, wdt_error, clear_lock,
        output wdg_sync, pulso, wdt_reset_n, sys_rst, fault_cnt, lockout, state
    );

    modport master (
        output enable, wdg_in, wdt_error, clear_lock,
        input  wdg_sync, pulso, wdt_reset_n, sys_rst, fault_cnt, lockout, state
    );
endinterface

// File: rtl/wdg_supervisor.sv
// Recovery sequencer around the watchdog timer: makes the sampling tick,
// arms/clears the timer, synchronizes the heartbeat, drives a timed recovery
// reset into the monitored system and locks out after repeated faults.
module wdg_supervisor #(
    parameter int TICK_DIV      = 50,
    parameter int RST_CYCLES    = 16,
    parameter int HOLDOFF_TICKS = 8,
    parameter int MAX_FAULTS    = 3,
    parameter int GOOD_TICKS    = 64
) (
    input  logic            clk,
    input  logic            reset,
    wdg_supervisor_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RUN     = 3'd2,
        RECOVER = 3'd3,
        HOLDOFF = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GOOD_TICKS + 1);
    localparam int HW = $clog2(HOLDOFF_TICKS + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(GOOD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLDOFF_TICKS - 1);
    localparam logic [RW-1:0] RST_MAX   = RW'(RST_CYCLES - 1);
    localparam logic [3:0]    FAULT_LIM = 4'(MAX_FAULTS);

    state_t        state_reg, state_next;
    logic [3:0]    fault_reg, fault_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [GW-1:0] good_reg;
    logic [HW-1:0] hold_reg;
    logic [RW-1:0] rst_cnt_reg;
    logic          sync1_reg, sync2_reg;
    logic          pulso_reg, wdt_reset_n_reg, sys_rst_reg, lockout_reg;

    logic       presc_run;
    logic       tick;
    logic [3:0] fault_inc;

    assign presc_run = (state_reg == RUN) || (state_reg == HOLDOFF);
    assign tick      = presc_run && (presc_reg == PRESC_MAX);
    assign fault_inc = (fault_reg == 4'hF) ? 4'hF : fault_reg + 4'd1;

    // Next-state and fault-count decision; enable=0 outranks a fault, a fault
    // outranks the good-tick clear, and LOCKOUT only listens to clear_lock.
    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        case (state_reg)
            IDLE: begin
                if (bus.enable) state_next = ARM;
            end
            ARM: begin
                state_next = bus.enable ? RUN : IDLE;
            end
            RUN: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end else if (bus.wdt_error) begin
                    fault_next = fault_inc;
                    state_next = (fault_inc == FAULT_LIM) ? LOCKOUT : RECOVER;
                end else if (tick && good_reg == GOOD_MAX) begin
                    fault_next = 4'd0;
                end
            end
            RECOVER: begin
                if (!bus.enable)              state_next = IDLE;
                else if (rst_cnt_reg == RST_MAX) state_next = HOLDOFF;
            end
            HOLDOFF: begin
                if (!bus.enable)                     state_next = IDLE;
                else if (tick && hold_reg == HOLD_MAX) state_next = ARM;
            end
            LOCKOUT: begin
                if (bus.clear_lock) begin
                    state_next = IDLE;
                    fault_next = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Prescaler only free-runs while staying in RUN or HOLDOFF.
        if (presc_run && state_next == state_reg && presc_reg != PRESC_MAX)
            presc_next = presc_reg + PW'(1);
        else
            presc_next = '0;
    end

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            fault_reg       <= 4'd0;
            presc_reg       <= '0;
            good_reg        <= '0;
            hold_reg        <= '0;
            rst_cnt_reg     <= '0;
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            pulso_reg       <= 1'b0;
            wdt_reset_n_reg <= 1'b0;
            sys_rst_reg     <= 1'b0;
            lockout_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            fault_reg <= fault_next;
            presc_reg <= presc_next;

            if (state_reg == ARM)
                good_reg <= '0;
            else if (state_reg == RUN && state_next == RUN && tick)
                good_reg <= (good_reg == GOOD_MAX) ? '0 : good_reg + GW'(1);

            if (state_next != HOLDOFF) hold_reg <= '0;
            else if (tick)             hold_reg <= hold_reg + HW'(1);

            if (state_reg == RECOVER && state_next == RECOVER)
                rst_cnt_reg <= rst_cnt_reg + RW'(1);
            else
                rst_cnt_reg <= '0;

            sync1_reg <= bus.wdg_in;
            sync2_reg <= sync1_reg;

            // Outputs follow the upcoming state so they line up with it.
            pulso_reg       <= (state_next == RUN) && (presc_next == PRESC_MAX);
            wdt_reset_n_reg <= (state_next == RUN);
            sys_rst_reg     <= (state_next == RECOVER) || (state_next == LOCKOUT);
            lockout_reg     <= (state_next == LOCKOUT);
        end
    end

    assign bus.wdg_sync    = sync2_reg;
    assign bus.pulso       = pulso_reg;
    assign bus.wdt_reset_n = wdt_reset_n_reg;
    assign bus.sys_rst     = sys_rst_reg;
    assign bus.fault_cnt   = fault_reg;
    assign bus.lockout     = lockout_reg;
    assign bus.state       = state_reg;
endmodule

// File: tb/tb_wdg_supervisor.sv
// Directed bench for wdg_supervisor with default parameters.
module tb_wdg_supervisor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wdg_supervisor_if bus();

    wdg_supervisor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input int target, input int bound);
        int k = 0;
        while (bus.state !== 3'(target) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.state, target);
    endtask

    // Number of negedges stepped until pulso is seen high (bounded).
    task automatic pulso_gap(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.pulso !== 1'b1 && n < 200);
    endtask

    task automatic pulse_error();
        bus.wdt_error = 1'b1;
        cyc(1);
        bus.wdt_error = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int p;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.wdg_in     = 1'b0;
        bus.wdt_error  = 1'b0;
        bus.clear_lock = 1'b0;
        cyc(3);
        chk("rst_state", bus.state, 0);
        chk("rst_wdt_reset_n", bus.wdt_reset_n, 0);
        chk("rst_sys_rst", bus.sys_rst, 0);
        chk("rst_fault_cnt", bus.fault_cnt, 0);
        chk("rst_lockout", bus.lockout, 0);
        chk("rst_pulso", bus.pulso, 0);
        chk("rst_wdg_sync", bus.wdg_sync, 0);

        // Synchronizer latency: two edges.
        reset      = 1'b0;
        bus.wdg_in = 1'b1;
        cyc(1);
        chk("sync_after_1", bus.wdg_sync, 0);
        cyc(1);
        chk("sync_after_2", bus.wdg_sync, 1);

        // Enable: ARM then RUN.
        bus.enable = 1'b1;
        cyc(1);
        chk("arm_state", bus.state, 1);
        chk("arm_wdt_reset_n", bus.wdt_reset_n, 0);
        cyc(1);
        chk("run_state", bus.state, 2);
        chk("run_wdt_reset_n", bus.wdt_reset_n, 1);
        chk("run_sys_rst", bus.sys_rst, 0);

        // First pulso on RUN cycle 50, then every 50 clocks, one cycle wide.
        pulso_gap(n);
        chk("pulso_first_gap", n, 49);
        cyc(1);
        chk("pulso_width", bus.pulso, 0);
        pulso_gap(n);
        chk("pulso_period_gap", n, 49);

        // Single fault: RECOVER for 16 clocks, HOLDOFF 400 clocks, ARM, RUN.
        pulse_error();
        chk("f1_state", bus.state, 3);
        chk("f1_sys_rst", bus.sys_rst, 1);
        chk("f1_wdt_reset_n", bus.wdt_reset_n, 0);
        chk("f1_fault_cnt", bus.fault_cnt, 1);
        n = 0;
        while (bus.sys_rst === 1'b1 && n < 100) begin
            n++;
            cyc(1);
        end
        chk("recover_len", n, 16);
        chk("holdoff_state", bus.state, 4);
        n = 0;
        p = 0;
        while (bus.state === 3'd4 && n < 1000) begin
            n++;
            if (bus.pulso === 1'b1) p++;
            cyc(1);
        end
        chk("holdoff_len", n, 400);
        chk("holdoff_pulso", p, 0);
        chk("rearm_state", bus.state, 1);
        cyc(1);
        chk("rerun_state", bus.state, 2);

        // clear_lock outside LOCKOUT is ignored.
        bus.clear_lock = 1'b1;
        cyc(1);
        bus.clear_lock = 1'b0;
        chk("stray_clear_fault", bus.fault_cnt, 1);
        chk("stray_clear_state", bus.state, 2);

        // Second and third faults -> LOCKOUT.
        cyc(5);
        pulse_error();
        chk("f2_fault_cnt", bus.fault_cnt, 2);
        chk("f2_state", bus.state, 3);
        wait_state("f2_back_to_run", 2, 600);
        cyc(3);
        pulse_error();
        chk("f3_fault_cnt", bus.fault_cnt, 3);
        chk("f3_state", bus.state, 5);
        chk("f3_lockout", bus.lockout, 1);
        chk("f3_sys_rst", bus.sys_rst, 1);
        bus.enable = 1'b0;
        cyc(3);
        chk("lock_enable_low_state", bus.state, 5);
        chk("lock_enable_low_sys_rst", bus.sys_rst, 1);
        bus.enable = 1'b1;
        cyc(2);
        chk("lock_held", bus.lockout, 1);
        bus.clear_lock = 1'b1;
        cyc(1);
        bus.clear_lock = 1'b0;
        chk("unlock_state", bus.state, 0);
        chk("unlock_fault_cnt", bus.fault_cnt, 0);
        chk("unlock_lockout", bus.lockout, 0);
        chk("unlock_sys_rst", bus.sys_rst, 0);
        cyc(1);
        chk("unlock_arm", bus.state, 1);
        cyc(1);
        chk("unlock_run", bus.state, 2);

        // One fault, then 64 error-free ticks clear fault_cnt.
        pulse_error();
        chk("g_fault_cnt", bus.fault_cnt, 1);
        wait_state("g_back_to_run", 2, 600);
        for (int i = 1; i <= 64; i++) begin
            pulso_gap(n);
            if (bus.pulso !== 1'b1) chk("good_tick_seen", bus.pulso, 1);
            if (i == 63) chk("good_tick63_fault", bus.fault_cnt, 1);
            if (i == 64) chk("good_tick64_cycle_fault", bus.fault_cnt, 1);
        end
        cyc(1);
        chk("good_clear_fault", bus.fault_cnt, 0);
        chk("good_clear_state", bus.state, 2);

        // enable=0 together with wdt_error: IDLE, no fault, no sys_rst.
        bus.enable    = 1'b0;
        bus.wdt_error = 1'b1;
        cyc(1);
        bus.wdt_error = 1'b0;
        chk("dis_err_state", bus.state, 0);
        chk("dis_err_fault", bus.fault_cnt, 0);
        chk("dis_err_sys_rst", bus.sys_rst, 0);
        cyc(2);
        chk("dis_err_sys_rst_later", bus.sys_rst, 0);

        // Asynchronous reset five clocks into RECOVER.
        bus.enable = 1'b1;
        wait_state("ar_run", 2, 5);
        pulse_error();
        chk("ar_recover", bus.state, 3);
        cyc(4);
        chk("ar_sys_rst_before", bus.sys_rst, 1);
        reset = 1'b1;
        #1;
        chk("ar_sys_rst", bus.sys_rst, 0);
        chk("ar_lockout", bus.lockout, 0);
        chk("ar_pulso", bus.pulso, 0);
        chk("ar_state", bus.state, 0);
        chk("ar_fault_cnt", bus.fault_cnt, 0);
        cyc(2);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
